// File: rtl/seg7_pkg.sv
// Shared display codes, widths and FSM state type for the 7-segment formatter.
package seg7_pkg;
  localparam logic [3:0] CODE_BLANK = 4'hA;
  localparam logic [3:0] CODE_MINUS = 4'hB;
  localparam int         DIG_W      = 4;
  localparam int         DISP_W     = 16;
  localparam int         NUM_BCD    = 3;
  localparam int         MAG_W      = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREP,
    ST_SHIFT,
    ST_DONE
  } seg7_fmt_state_t;
endpackage

// File: rtl/dd_step.sv
// One double-dabble step: add-3 correction on each BCD nibble, then shift left by one.
module dd_step
  import seg7_pkg::*;
(
  input  logic [NUM_BCD*DIG_W-1:0] bcd_i,
  input  logic                     shift_in,
  output logic [NUM_BCD*DIG_W-1:0] bcd_o
);

  logic [NUM_BCD*DIG_W-1:0] adj;

  always_comb begin
    adj = bcd_i;
    for (int i = 0; i < NUM_BCD; i++) begin
      if (bcd_i[i*DIG_W +: DIG_W] >= 4'd5)
        adj[i*DIG_W +: DIG_W] = bcd_i[i*DIG_W +: DIG_W] + 4'd3;
    end
    // The top adjusted bit is always 0 for magnitudes below 1000, so it drops out.
    bcd_o = (NUM_BCD*DIG_W)'({adj, shift_in});
  end

endmodule

// File: rtl/seg7_fmt.sv
// Signed hundredths to 4-digit 7-segment code word {sign, units, tenths, hundredths}.
// Define SEG7_FMT_OVF_EN to add the ovf port and show "s-.--" on saturation.
//
// state  | meaning
// IDLE   | waiting for start; bits held
// PREP   | sign/magnitude, clamp to SAT_VAL, load shifter
// SHIFT  | 10 double-dabble steps
// DONE   | publish bits, pulse done
module seg7_fmt
  import seg7_pkg::*;
#(
  parameter int IN_W    = 16,
  parameter int SAT_VAL = 999
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IN_W-1:0]   value,
  output logic              busy,
  output logic              done,
  output logic [DISP_W-1:0] bits
`ifdef SEG7_FMT_OVF_EN
  ,
  output logic              ovf
`endif
);

  localparam logic [IN_W:0] SAT_EXT = (IN_W+1)'(SAT_VAL);
  localparam logic [DISP_W-1:0] BITS_RST = {CODE_BLANK, {(NUM_BCD*DIG_W){1'b0}}};

  seg7_fmt_state_t          state_q, state_d;
  logic [IN_W-1:0]          val_q, val_d;
  logic                     sign_q, sign_d;
  logic [MAG_W-1:0]         mag_q, mag_d;
  logic [NUM_BCD*DIG_W-1:0] bcd_q, bcd_d;
  logic [3:0]               cnt_q, cnt_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [DISP_W-1:0]        bits_q, bits_d;
`ifdef SEG7_FMT_OVF_EN
  logic                     sat_q, sat_d;
  logic                     ovf_q, ovf_d;
`endif

  logic [IN_W:0]            val_ext, mag_full;
  logic                     sat;
  logic [NUM_BCD*DIG_W-1:0] bcd_step, digits;

  // One extra bit keeps the most negative input from wrapping on negation.
  assign val_ext  = {val_q[IN_W-1], val_q};
  assign mag_full = val_q[IN_W-1] ? ((IN_W+1)'(0) - val_ext) : val_ext;
  assign sat      = mag_full > SAT_EXT;

  dd_step u_step (
    .bcd_i    (bcd_q),
    .shift_in (mag_q[MAG_W-1]),
    .bcd_o    (bcd_step)
  );

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bits_d  = bits_q;
    digits  = bcd_q;
`ifdef SEG7_FMT_OVF_EN
    sat_d   = sat_q;
    ovf_d   = ovf_q;
    if (sat_q) digits = {NUM_BCD{CODE_MINUS}};
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          val_d   = value;
          busy_d  = 1'b1;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        sign_d  = val_q[IN_W-1];
        mag_d   = sat ? MAG_W'(SAT_VAL) : mag_full[MAG_W-1:0];
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = ST_SHIFT;
`ifdef SEG7_FMT_OVF_EN
        sat_d   = sat;
`endif
      end
      ST_SHIFT: begin
        bcd_d = bcd_step;
        mag_d = {mag_q[MAG_W-2:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) state_d = ST_DONE;
      end
      ST_DONE: begin
        bits_d  = {sign_q ? CODE_MINUS : CODE_BLANK, digits};
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
`ifdef SEG7_FMT_OVF_EN
        ovf_d   = sat_q;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      val_q   <= '0;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bits_q  <= BITS_RST;
`ifdef SEG7_FMT_OVF_EN
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bits_q  <= bits_d;
`ifdef SEG7_FMT_OVF_EN
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bits = bits_q;
`ifdef SEG7_FMT_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
